ysyx_22041752_aser_pipe: RTL and testbench
==========================================

// Module: ysyx_22041752_aser_pipe
// PURPOSE
//  Parametrised, segmented-carry pipelined adder/subtractor for the EXU integer path.
//  Splits a WIDTH-bit add/sub into STAGES registered carry segments to meet timing.
//  Adds RV64 word ops (ADDW/SUBW), carry/overflow/zero flags and valid/ready flow control.
//  Sits between the ID/EX issue register and the EX/MEM writeback mux; carries an opaque tag.
// PARAMETERS
//  WIDTH   64  operand/result width; even, multiple of STAGES
//  STAGES  2   carry segments = pipeline depth (1..8); SEG = WIDTH/STAGES bits per stage
//  TAG_W   5   width of the pass-through tag (rd index)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       operation presented
//  in_ready   out  1       operation accepted when in_valid & in_ready
//  in_op      in   2       00 ADD, 01 SUB, 10 ADDW, 11 SUBW
//  in_sat     in   1       request signed saturation (only with SAT_EN)
//  in_a       in   WIDTH   operand a
//  in_b       in   WIDTH   operand b
//  in_tag     in   TAG_W   opaque tag, returned unchanged
//  out_valid  out  1       result valid
//  out_ready  in   1       result consumed when out_valid & out_ready
//  out_result out  WIDTH   result
//  out_cout   out  1       carry out of bit WIDTH-1 (SUB: 1 = no borrow)
//  out_ovf    out  1       signed overflow of the full-width operation
//  out_zero   out  1       out_result == 0
//  out_tag    out  TAG_W   tag of this result
// BEHAVIOUR
//  - Arithmetic: y = sub ? ~b : b; {cout,sum} = a + y + sub, carry rippled across stages.
//  - Stage k adds SEG bits [k*SEG +: SEG] with carry-in from stage k-1's carry register;
//    upper operand slices are skewed in, lower sum slices deskewed out; latency = STAGES.
//  - ovf = (a[W-1] == y[W-1]) & (sum[W-1] != a[W-1]); computed in last stage.
//  - ADDW/SUBW: result = sign-extend(sum[WIDTH/2-1:0]); cout/ovf still full-width; zero on result.
//  - Flow: advance = ~out_valid | out_ready; every stage register (data+valid) loads when
//    advance; in_ready = advance. Bubbles are not squeezed. No combinational in->out path
//    except in_ready depending on out_ready.
//  - Accepted ops emerge in order, exactly once; while out_valid & ~out_ready all outputs hold.
//  - Reset (async, any cycle incl. mid-operation): all stage valids 0, data regs 0;
//    out_valid=0, out_result=0, flags=0, out_tag=0, in_ready=1 after release. In-flight ops lost.
//  - Simultaneous output consume and input accept in same cycle is legal, full throughput 1/cycle.
//  - STAGES=1: single registered stage, latency 1.
// CONFIGURATION
//  YSYX_22041752_ASER_SAT_EN defined: for ADD/SUB with in_sat=1 and ovf=1, result clamps to
//   0x7FF..F (a non-negative) or 0x800..0 (a negative); out_ovf still reports raw overflow;
//   zero reflects clamped result. Ignored for ADDW/SUBW.
//  Not defined: in_sat ignored, no clamp logic; result always the wrapped sum.
// STRUCTURE
//  - Package ysyx_22041752_aser_pkg: op encodings (OP_ADD/SUB/ADDW/SUBW), op-decode helpers
//    (is_sub, is_word), stage-count legality check constant.
//  - Sub-module ysyx_22041752_aser_seg: SEG-bit add of a/y slice + cin, registered sum slice
//    and carry, with load enable; instantiated STAGES times in a generate loop.
//  - Top: skew/deskew shift registers, valid/tag/op pipeline, flag/word/sat logic in last stage.
// TESTING (WIDTH=64, STAGES=2, TAG_W=5)
//  - ADD a=0xFFFF_FFFF_FFFF_FFFF b=1 tag=3 -> 2 cycles later result=0, cout=1, zero=1, ovf=0, tag=3.
//  - SUB a=5 b=7 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0, zero=0.
//  - ADDW a=0x7FFF_FFFF b=1 -> result=0xFFFF_FFFF_8000_0000; SUBW a=0 b=1 -> 0xFFFF_FFFF_FFFF_FFFF.
//  - ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 sat=1 -> ovf=1; result 0x8000_0000_0000_0000 without
//    SAT_EN, 0x7FFF_FFFF_FFFF_FFFF with SAT_EN.
//  - Stream 6 back-to-back ops, out_ready low 3 cycles mid-stream -> in_ready low same cycles,
//    outputs held stable, all 6 results in order with correct tags, no dup/loss.
//  - rst_n low with 2 ops in flight -> out_valid=0 immediately (async), no stale result after release.

Source files
------------

// File: rtl/ysyx_22041752_aser_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_aser_pkg
//  Shared definitions for the segmented-carry pipelined adder/subtractor:
//  operation encodings, op-decode helpers and the configuration legality
//  check used by the top level at elaboration time.
//  Optional feature macro used by the users of this package:
//    YSYX_22041752_ASER_SAT_EN  (signed saturation for ADD/SUB)
// ---------------------------------------------------------------------------
package ysyx_22041752_aser_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDW = 2'b10,
      OP_SUBW = 2'b11
   } aser_op_e;

   localparam int MAX_STAGES = 8;

   // Subtraction inverts b and injects a carry-in of 1.
   function automatic logic is_sub(input logic [1:0] op);
      return (op == OP_SUB) || (op == OP_SUBW);
   endfunction

   // Word ops sign-extend the low half of the sum.
   function automatic logic is_word(input logic [1:0] op);
      return (op == OP_ADDW) || (op == OP_SUBW);
   endfunction

   // Legal shapes: 1..MAX_STAGES segments, even width split evenly.
   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= MAX_STAGES) && (width >= 2) &&
             (width % 2 == 0) && (width % stages == 0);
   endfunction

endpackage

// File: rtl/ysyx_22041752_aser_if.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_aser_if
//  Issue and result handshake bundle of the pipelined adder/subtractor.
//  Ports (signals):
//    in_valid/in_ready, in_op[1:0], in_sat, in_a, in_b, in_tag   issue side
//    out_valid/out_ready, out_result, out_cout, out_ovf, out_zero,
//    out_tag                                                      result side
//  Modports:
//    slave  - the adder (consumes the issue side, produces results)
//    master - the issuer/consumer around it (ID/EX register, writeback)
// ---------------------------------------------------------------------------
interface ysyx_22041752_aser_if #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic             in_sat;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_op, in_sat, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero, out_tag
   );

   modport master (
      output in_valid, in_op, in_sat, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero, out_tag
   );
endinterface

// File: rtl/ysyx_22041752_aser_seg.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_aser_seg
//  One carry segment: adds a SEG-bit slice of a and y (y = b or ~b) plus a
//  carry-in, and registers the sum slice and the carry-out when en is high.
//  Ports:
//    clk, rst_n   clock, asynchronous active-low reset
//    en           load enable (pipeline advance)
//    a, y, cin    slice operands and carry-in
//    sum, cout    registered sum slice and carry-out
// ---------------------------------------------------------------------------
module ysyx_22041752_aser_seg #(
   parameter int SEG = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] y,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);
   logic [SEG:0] total;

   assign total = {1'b0, a} + {1'b0, y} + {{SEG{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         sum  <= total[SEG-1:0];
         cout <= total[SEG];
      end
   end
endmodule

// File: rtl/ysyx_22041752_aser_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_aser_pipe
//  Segmented-carry pipelined adder/subtractor for the EXU integer path.
//  A WIDTH-bit add/sub is split into STAGES segments of SEG bits; level k
//  adds slice k using the carry registered by level k-1. Operand slices not
//  yet consumed travel along with the op (skew) and finished sum slices are
//  carried forward until the last level (deskew). Latency = STAGES.
//  Ports:
//    clk, rst_n   clock, asynchronous active-low reset
//    bus          ysyx_22041752_aser_if.slave (issue + result handshakes)
//  Configuration macro:
//    YSYX_22041752_ASER_SAT_EN  clamp ADD/SUB results on signed overflow
//                               when in_sat=1 (word ops unaffected)
// ---------------------------------------------------------------------------
module ysyx_22041752_aser_pipe
   import ysyx_22041752_aser_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   ysyx_22041752_aser_if.slave bus
);
   localparam int SEG = WIDTH / STAGES;
   localparam int L   = STAGES - 1;
   localparam int HW  = WIDTH / 2;

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("ysyx_22041752_aser_pipe: illegal WIDTH/STAGES combination");
   end

   // Handshake: a transfer happens on a rising edge where valid & ready.
   // The whole pipe moves as one (adv); the last level frees up when it is
   // empty or being consumed, so in_ready = ~out_valid | out_ready. Bubbles
   // travel with the data rather than being squeezed out.
   logic             adv;
   logic [WIDTH-1:0] y_in;

   assign adv          = ~g_lvl[L].v_q | bus.out_ready;
   assign bus.in_ready = adv;
   assign y_in         = is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;

`ifndef YSYX_22041752_ASER_SAT_EN
   logic sat_unused;
   assign sat_unused = bus.in_sat;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_lvl
      logic             v_q, v_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [1:0]       op_q, op_d;
      logic             a_msb_q, a_msb_d;
      logic             y_msb_q, y_msb_d;
      logic [SEG-1:0]   seg_a, seg_y, seg_s;
      logic             seg_cin, seg_c;
      logic [WIDTH-1:0] acc;   // sum slices 0..k, zeros above
`ifdef YSYX_22041752_ASER_SAT_EN
      logic             sat_q, sat_d;
`endif

      if (k == 0) begin : g_src
         assign v_d     = bus.in_valid;
         assign tag_d   = bus.in_tag;
         assign op_d    = bus.in_op;
         assign a_msb_d = bus.in_a[WIDTH-1];
         assign y_msb_d = y_in[WIDTH-1];
         assign seg_a   = bus.in_a[SEG-1:0];
         assign seg_y   = y_in[SEG-1:0];
         assign seg_cin = is_sub(bus.in_op);
         assign acc     = WIDTH'(seg_s);
`ifdef YSYX_22041752_ASER_SAT_EN
         assign sat_d   = bus.in_sat;
`endif
      end else begin : g_src
         logic [WIDTH-1:0] dsk_q;

         assign v_d     = g_lvl[k-1].v_q;
         assign tag_d   = g_lvl[k-1].tag_q;
         assign op_d    = g_lvl[k-1].op_q;
         assign a_msb_d = g_lvl[k-1].a_msb_q;
         assign y_msb_d = g_lvl[k-1].y_msb_q;
         // The lowest skewed slice of the previous level is this level's slice.
         assign seg_a   = g_lvl[k-1].g_up.a_up[SEG-1:0];
         assign seg_y   = g_lvl[k-1].g_up.y_up[SEG-1:0];
         assign seg_cin = g_lvl[k-1].seg_c;
         assign acc     = dsk_q | (WIDTH'(seg_s) << (k * SEG));
`ifdef YSYX_22041752_ASER_SAT_EN
         assign sat_d   = g_lvl[k-1].sat_q;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   dsk_q <= '0;
            else if (adv) dsk_q <= g_lvl[k-1].acc;
         end
      end

      // Operand slices still to be added by later levels.
      if (k < L) begin : g_up
         localparam int UPW = (L - k) * SEG;
         logic [UPW-1:0] a_up, y_up, a_nx, y_nx;

         if (k == 0) begin : g_in
            assign a_nx = bus.in_a[WIDTH-1:SEG];
            assign y_nx = y_in[WIDTH-1:SEG];
         end else begin : g_in
            assign a_nx = g_lvl[k-1].g_up.a_up[UPW+SEG-1:SEG];
            assign y_nx = g_lvl[k-1].g_up.y_up[UPW+SEG-1:SEG];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_up <= '0;
               y_up <= '0;
            end else if (adv) begin
               a_up <= a_nx;
               y_up <= y_nx;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q     <= 1'b0;
            tag_q   <= '0;
            op_q    <= OP_ADD;
            a_msb_q <= 1'b0;
            y_msb_q <= 1'b0;
`ifdef YSYX_22041752_ASER_SAT_EN
            sat_q   <= 1'b0;
`endif
         end else if (adv) begin
            v_q     <= v_d;
            tag_q   <= tag_d;
            op_q    <= op_d;
            a_msb_q <= a_msb_d;
            y_msb_q <= y_msb_d;
`ifdef YSYX_22041752_ASER_SAT_EN
            sat_q   <= sat_d;
`endif
         end
      end

      ysyx_22041752_aser_seg #(.SEG(SEG)) u_seg (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (adv),
         .a    (seg_a),
         .y    (seg_y),
         .cin  (seg_cin),
         .sum  (seg_s),
         .cout (seg_c)
      );
   end

   // Result/flag formation from the last level registers. Everything here
   // depends only on registers, so outputs hold while the pipe is stalled.
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] res;
   logic             ovf;

   assign sum = g_lvl[L].acc;
   assign ovf = (g_lvl[L].a_msb_q == g_lvl[L].y_msb_q) &
                (sum[WIDTH-1] != g_lvl[L].a_msb_q);

   always_comb begin
      res = sum;
      if (is_word(g_lvl[L].op_q)) begin
         res = {{HW{sum[HW-1]}}, sum[HW-1:0]};
      end
`ifdef YSYX_22041752_ASER_SAT_EN
      else if (g_lvl[L].sat_q && ovf) begin
         // Clamp toward the sign of a: positive max or negative min.
         res = g_lvl[L].a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   assign bus.out_valid  = g_lvl[L].v_q;
   assign bus.out_result = res;
   assign bus.out_cout   = g_lvl[L].seg_c;
   assign bus.out_ovf    = ovf;
   // Gated by valid so the reset/idle state reports zero=0.
   assign bus.out_zero   = g_lvl[L].v_q & (res == '0);
   assign bus.out_tag    = g_lvl[L].tag_q;
endmodule

// File: tb/tb_ysyx_22041752_aser_pipe.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041752_aser_pipe
//  Directed vectors with hand-computed results, a driver that pushes the
//  expected response into exp_q on acceptance, and an independent monitor
//  that pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_ysyx_22041752_aser_pipe;
   import ysyx_22041752_aser_pkg::*;

   localparam int WIDTH  = 64;
   localparam int STAGES = 2;
   localparam int TAG_W  = 5;
   localparam int EW     = WIDTH + 3 + TAG_W;

`ifdef YSYX_22041752_ASER_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]       op;
      logic             sat;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] res;
      logic             cout;
      logic             ovf;
      logic             zero;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [EW-1:0] exp_q[$];
   vec_t          dir_v[10];
   vec_t          str_v[6];

   ysyx_22041752_aser_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   ysyx_22041752_aser_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   function automatic vec_t mk(input logic [1:0] op, input logic sat,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] res,
                               input logic cout, input logic ovf, input logic zero);
      vec_t v;
      v.op = op; v.sat = sat; v.a = a; v.b = b; v.tag = tag;
      v.res = res; v.cout = cout; v.ovf = ovf; v.zero = zero;
      return v;
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input vec_t v, input bit chk);
      int n   = 0;
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = v.op;
      bus.in_sat   = v.sat;
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      bus.in_tag   = v.tag;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) begin
         if (chk) exp_q.push_back({v.tag, v.zero, v.ovf, v.cout, v.res});
      end else begin
         checks++;
         errors++;
         $display("FAIL issue_timeout tag=%0d: in_ready stayed 0 for %0d cycles", v.tag, n);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [EW-1:0] got;
      logic [EW-1:0] held;
      logic [EW-1:0] e;
      bit            hold_pending;
      hold_pending = 1'b0;
      held         = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_pending = 1'b0;
         end else begin
            got = {bus.out_tag, bus.out_zero, bus.out_ovf, bus.out_cout, bus.out_result};
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
               errors++;
               $display("FAIL in_ready: got %b expected %b", bus.in_ready,
                        (!bus.out_valid || bus.out_ready));
            end
            if (hold_pending) begin
               checks++;
               if ({bus.out_valid, got} !== {1'b1, held}) begin
                  errors++;
                  $display("FAIL hold: got valid=%b %h expected valid=1 %h",
                           bus.out_valid, got, held);
               end
            end
            hold_pending = 1'b0;
            if (bus.out_valid) begin
               if (bus.out_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_result: got %h expected no output", got);
                  end else begin
                     e = exp_q.pop_front();
                     if (got !== e) begin
                        errors++;
                        $display("FAIL result tag=%0d: got {tag,z,v,c,res}=%h expected %h",
                                 e[EW-1 -: TAG_W], got, e);
                     end
                  end
               end else begin
                  held         = got;
                  hold_pending = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      dir_v[0] = mk(OP_ADD,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd3,
                    64'h0, 1'b1, 1'b0, 1'b1);
      dir_v[1] = mk(OP_SUB,  1'b0, 64'h5, 64'h7, 5'd4,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      dir_v[2] = mk(OP_ADDW, 1'b0, 64'h7FFF_FFFF, 64'h1, 5'd5,
                    64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0);
      dir_v[3] = mk(OP_SUBW, 1'b0, 64'h0, 64'h1, 5'd6,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
      dir_v[4] = mk(OP_ADD,  1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'd7,
                    SAT_ON ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000,
                    1'b0, 1'b1, 1'b0);
      dir_v[5] = mk(OP_SUB,  1'b1, 64'h8000_0000_0000_0000, 64'h1, 5'd8,
                    SAT_ON ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b1, 1'b0);
      dir_v[6] = mk(OP_SUB,  1'b0, 64'd10, 64'd10, 5'd9,
                    64'h0, 1'b1, 1'b0, 1'b1);
      dir_v[7] = mk(OP_ADDW, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'd20,
                    64'h0, 1'b0, 1'b1, 1'b1);
      dir_v[8] = mk(OP_ADD,  1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 5'd21,
                    64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
      dir_v[9] = mk(OP_SUB,  1'b0, 64'h0, 64'h8000_0000_0000_0000, 5'd22,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

      str_v[0] = mk(OP_ADD,  1'b0, 64'd1, 64'd2, 5'd10, 64'd3, 1'b0, 1'b0, 1'b0);
      str_v[1] = mk(OP_SUB,  1'b0, 64'd100, 64'd1, 5'd11, 64'd99, 1'b1, 1'b0, 1'b0);
      str_v[2] = mk(OP_ADDW, 1'b0, 64'hFFFF_FFFF, 64'h1, 5'd12, 64'h0, 1'b0, 1'b0, 1'b1);
      str_v[3] = mk(OP_ADD,  1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd13,
                    64'h0, 1'b1, 1'b1, 1'b1);
      str_v[4] = mk(OP_SUBW, 1'b0, 64'd3, 64'd5, 5'd14,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      str_v[5] = mk(OP_ADD,  1'b0, 64'h1234, 64'h4321, 5'd15, 64'h5555, 1'b0, 1'b0, 1'b0);

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = OP_ADD;
      bus.in_sat    = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_flags", 64'({bus.out_cout, bus.out_ovf, bus.out_zero}), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Directed vectors, back-to-back
      for (int i = 0; i < 10; i++) issue(dir_v[i], 1'b1);
      drain();

      // Stream of 6 with a 3-cycle output stall in the middle
      fork
         begin
            for (int i = 0; i < 6; i++) issue(str_v[i], 1'b1);
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two ops in flight: outputs must drop at once, and the
      // lost ops must never reappear.
      issue(str_v[0], 1'b0);
      issue(str_v[1], 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_rst_out_result", bus.out_result, 64'd0);
      check("async_rst_out_tag", 64'(bus.out_tag), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (5) @(posedge clk);
      #1;

      // Recovery after reset
      issue(mk(OP_ADD, 1'b0, 64'd1, 64'd2, 5'd7, 64'd3, 1'b0, 1'b0, 1'b0), 1'b1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
